// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution pass sequencer and column counter.
package conv_pkg;

   localparam int IMG_W = 5;
   localparam int KER_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      LOAD,
      RUN,
      PSUM,
      DONE
   } state_e;

   // Output side length for an I x I map under a K x K kernel; s=1 selects stride 2.
   function automatic logic [IMG_W-1:0] out_dim(
      input logic [IMG_W-1:0] i,
      input logic [KER_W-1:0] k,
      input logic             s
   );
      logic [IMG_W-1:0] span;
      span = i - IMG_W'(k);
      return s ? ((span >> 1) + IMG_W'(1)) : (span + IMG_W'(1));
   endfunction

   // A pass only makes sense with a non-empty kernel that fits inside the image.
   function automatic logic cfg_legal(
      input logic [IMG_W-1:0] i,
      input logic [KER_W-1:0] k
   );
      return (k != '0) && (i >= IMG_W'(k));
   endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Control bundle between the host/column-counter side (master) and the pass sequencer (slave).
interface conv_layer_sequencer_if;
   import conv_pkg::*;

   logic             start;
   logic [IMG_W-1:0] image_size;
   logic [KER_W-1:0] kernel_size;
   logic             stride;
   logic             in_ready;
   logic             col_max_reached;
   logic             psum_ready;

   logic             busy;
   logic             cfg_load;
   logic             col_enable;
   logic [KER_W-1:0] krow;
   logic [IMG_W-1:0] orow;
   logic             psum_valid;
   logic             row_done;
   logic             done;
   logic             cfg_err;

   modport master (
      output start, image_size, kernel_size, stride, in_ready, col_max_reached, psum_ready,
      input  busy, cfg_load, col_enable, krow, orow, psum_valid, row_done, done, cfg_err
   );

   modport slave (
      input  start, image_size, kernel_size, stride, in_ready, col_max_reached, psum_ready,
      output busy, cfg_load, col_enable, krow, orow, psum_valid, row_done, done, cfg_err
   );

endinterface

// File: rtl/conv_layer_sequencer.sv
// Scheduler for one convolution pass: latches the config, walks kernel rows and
// output rows, gates column counting on input data and hands each finished row
// to the psum write-back path.
module conv_layer_sequencer
   import conv_pkg::*;
(
   input logic                   clk,
   input logic                   rst_n,
   conv_layer_sequencer_if.slave bus
);

   state_e           state_q, state_d;
   logic [IMG_W-1:0] img_q, img_d;
   logic [KER_W-1:0] ker_q, ker_d;
   logic             stride_q, stride_d;
   logic [KER_W-1:0] krow_q, krow_d;
   logic [IMG_W-1:0] orow_q, orow_d;
   logic             cfg_err_q, cfg_err_d;

   logic [IMG_W-1:0] o_dim;
   logic [IMG_W-1:0] last_orow;
   logic [KER_W-1:0] last_krow;
   logic             col_en;
   logic             col_wrap;
   logic             psum_fire;
   logic             final_row;

   assign o_dim     = out_dim(img_q, ker_q, stride_q);
   assign last_orow = o_dim - IMG_W'(1);
   assign last_krow = ker_q - KER_W'(1);
   assign col_en    = (state_q == RUN) && bus.in_ready;
   assign col_wrap  = col_en && bus.col_max_reached;
   assign psum_fire = (state_q == PSUM) && bus.psum_ready;
   assign final_row = (orow_q == last_orow);

   assign bus.busy       = (state_q != IDLE);
   assign bus.cfg_load   = (state_q == LOAD);
   assign bus.col_enable = col_en;
   assign bus.krow       = krow_q;
   assign bus.orow       = orow_q;
   assign bus.psum_valid = (state_q == PSUM);
   assign bus.row_done   = psum_fire && !final_row;
   assign bus.done       = (state_q == DONE);
   assign bus.cfg_err    = cfg_err_q;

   // Next-state and counter update for the pass FSM.
   always_comb begin
      state_d   = state_q;
      img_d     = img_q;
      ker_d     = ker_q;
      stride_d  = stride_q;
      krow_d    = krow_q;
      orow_d    = orow_q;
      cfg_err_d = cfg_err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               img_d     = bus.image_size;
               ker_d     = bus.kernel_size;
               stride_d  = bus.stride;
               cfg_err_d = 1'b0;
               state_d   = CHECK;
            end
         end
         CHECK: begin
            if (cfg_legal(img_q, ker_q)) begin
               krow_d  = '0;
               orow_d  = '0;
               state_d = LOAD;
            end else begin
               cfg_err_d = 1'b1;
               state_d   = IDLE;
            end
         end
         LOAD: begin
            state_d = RUN;
         end
         RUN: begin
            if (col_wrap) begin
               if (krow_q == last_krow) begin
                  state_d = PSUM;
               end else begin
                  krow_d = krow_q + KER_W'(1);
               end
            end
         end
         PSUM: begin
            if (psum_fire) begin
               if (final_row) begin
                  state_d = DONE;
               end else begin
                  orow_d  = orow_q + IMG_W'(1);
                  krow_d  = '0;
                  state_d = RUN;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, config and counter registers; reset drops any pass in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         img_q     <= '0;
         ker_q     <= '0;
         stride_q  <= 1'b0;
         krow_q    <= '0;
         orow_q    <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         img_q     <= img_d;
         ker_q     <= ker_d;
         stride_q  <= stride_d;
         krow_q    <= krow_d;
         orow_q    <= orow_d;
         cfg_err_q <= cfg_err_d;
      end
   end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer: directed and randomized passes
// compared cycle by cycle against a count-based reference model.
module tb_conv_layer_sequencer;
   import conv_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   conv_layer_sequencer_if bus ();

   conv_layer_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: a pass is described by cycles since start, column wraps
   // seen and psum handshakes completed.
   int passActive, sinceStart, mI, mK, mS, mO, mLegal;
   int wraps, hs, heldK, heldO, mCfgErr, ceCount, psumWait;
   int drvI, drvK, drvS;
   int obsColEn, obsRowDone, obsDone, obsLoad;
   logic expPsum, expColEn;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic ir, input logic cm, input logic pr);
      logic running, expDone, expLoad, expRowDone;
      int   expK, expO;
      @(negedge clk);
      bus.start           = st;
      bus.in_ready        = ir;
      bus.col_max_reached = cm;
      bus.psum_ready      = pr;
      bus.image_size      = IMG_W'(drvI);
      bus.kernel_size     = KER_W'(drvK);
      bus.stride          = 1'(drvS);
      #1;
      running    = (passActive != 0) && (sinceStart >= 3) && (hs < mO);
      expPsum    = running && (wraps == mK * (hs + 1));
      expColEn   = running && !expPsum && ir;
      expDone    = (passActive != 0) && (sinceStart >= 3) && (hs == mO);
      expLoad    = (passActive != 0) && (sinceStart == 2);
      expRowDone = expPsum && pr && (hs < mO - 1);
      if ((passActive != 0) && (sinceStart >= 3)) begin
         if (hs == mO) begin
            expK = mK - 1;
            expO = mO - 1;
         end else if (expPsum) begin
            expK = mK - 1;
            expO = hs;
         end else begin
            expK = wraps - mK * hs;
            expO = hs;
         end
      end else if ((passActive != 0) && (sinceStart == 2)) begin
         expK = 0;
         expO = 0;
      end else begin
         expK = heldK;
         expO = heldO;
      end
      checkOutput("busy",       32'(bus.busy),       32'(passActive != 0));
      checkOutput("cfg_load",   32'(bus.cfg_load),   32'(expLoad));
      checkOutput("col_enable", 32'(bus.col_enable), 32'(expColEn));
      checkOutput("psum_valid", 32'(bus.psum_valid), 32'(expPsum));
      checkOutput("row_done",   32'(bus.row_done),   32'(expRowDone));
      checkOutput("done",       32'(bus.done),       32'(expDone));
      checkOutput("cfg_err",    32'(bus.cfg_err),    32'(mCfgErr));
      checkOutput("krow",       32'(bus.krow),       32'(expK));
      checkOutput("orow",       32'(bus.orow),       32'(expO));
      if (bus.col_enable === 1'b1) obsColEn++;
      if (bus.row_done === 1'b1)   obsRowDone++;
      if (bus.done === 1'b1)       obsDone++;
      if (bus.cfg_load === 1'b1)   obsLoad++;
      @(posedge clk);
      if (passActive == 0) begin
         if (st) begin
            passActive = 1;
            sinceStart = 1;
            mI         = drvI;
            mK         = drvK;
            mS         = drvS;
            mLegal     = ((mK >= 1) && (mI >= mK)) ? 1 : 0;
            mO         = (mLegal == 0) ? 0 : ((mS != 0) ? ((mI - mK) / 2 + 1) : (mI - mK + 1));
            wraps      = 0;
            hs         = 0;
            ceCount    = 0;
            psumWait   = 0;
            mCfgErr    = 0;
         end
      end else if (sinceStart == 1) begin
         if (mLegal == 0) begin
            passActive = 0;
            mCfgErr    = 1;
         end else begin
            sinceStart = 2;
            heldK      = 0;
            heldO      = 0;
         end
      end else if (sinceStart == 2) begin
         sinceStart = 3;
      end else if (hs == mO) begin
         passActive = 0;
         heldK      = mK - 1;
         heldO      = mO - 1;
      end else begin
         if (expColEn) ceCount++;
         if (expColEn && cm) wraps++;
         if (expPsum) begin
            if (pr) begin
               hs++;
               psumWait = 0;
            end else begin
               psumWait++;
            end
         end
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      bus.start           = 1'b0;
      bus.in_ready        = 1'b0;
      bus.col_max_reached = 1'b0;
      bus.psum_ready      = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checkOutput("rst_busy",       32'(bus.busy),       32'd0);
      checkOutput("rst_cfg_load",   32'(bus.cfg_load),   32'd0);
      checkOutput("rst_col_enable", 32'(bus.col_enable), 32'd0);
      checkOutput("rst_psum_valid", 32'(bus.psum_valid), 32'd0);
      checkOutput("rst_row_done",   32'(bus.row_done),   32'd0);
      checkOutput("rst_done",       32'(bus.done),       32'd0);
      checkOutput("rst_cfg_err",    32'(bus.cfg_err),    32'd0);
      checkOutput("rst_krow",       32'(bus.krow),       32'd0);
      checkOutput("rst_orow",       32'(bus.orow),       32'd0);
      passActive = 0;
      sinceStart = 0;
      heldK      = 0;
      heldO      = 0;
      mCfgErr    = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // mode 0: random inputs; 1: in_ready high, col_max every 3rd column, psum_ready after 5 waits;
   // 2: in_ready toggling 1010 with col_max always high. abortO >= 0 stops in RUN at (abortK, abortO).
   task automatic runPass(input int I, input int K, input int S, input int mode,
                          input int abortK, input int abortO);
      int   steps;
      logic st, ir, cm, pr;
      drvI       = I;
      drvK       = K;
      drvS       = S;
      obsColEn   = 0;
      obsRowDone = 0;
      obsDone    = 0;
      obsLoad    = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      steps = 0;
      while ((passActive != 0) && (steps < 2000)) begin
         if ((abortO >= 0) && (sinceStart >= 3) && (hs == abortO) && (hs < mO) &&
             (wraps - mK * hs == abortK) && (wraps != mK * (hs + 1))) break;
         st = 1'b0; ir = 1'b0; cm = 1'b0; pr = 1'b0;
         case (mode)
            1: begin
               ir = 1'b1;
               cm = ((ceCount % 3) == 2);
               pr = (psumWait >= 5);
            end
            2: begin
               st = 1'($urandom_range(0, 1));
               ir = ((steps % 2) == 0);
               cm = 1'b1;
               pr = 1'($urandom_range(0, 1));
            end
            default: begin
               st   = 1'($urandom_range(0, 1));
               ir   = ($urandom_range(0, 3) != 0);
               cm   = 1'($urandom_range(0, 1));
               pr   = 1'($urandom_range(0, 1));
               drvI = $urandom_range(0, 31);
               drvK = $urandom_range(0, 7);
               drvS = $urandom_range(0, 1);
            end
         endcase
         applyStimulus(st, ir, cm, pr);
         steps++;
      end
      if (steps >= 2000) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL pass_timeout: observed %0d steps required fewer than 2000", steps);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drvI = 0; drvK = 0; drvS = 0;
      passActive = 0; sinceStart = 0; mI = 0; mK = 0; mS = 0; mO = 0; mLegal = 0;
      wraps = 0; hs = 0; heldK = 0; heldO = 0; mCfgErr = 0; ceCount = 0; psumWait = 0;
      bus.image_size = '0; bus.kernel_size = '0; bus.stride = 1'b0;
      doReset();

      // I=5 K=3 stride 1: 3 rows x 3 kernel rows x 3 columns, psum held off 5 cycles each row.
      runPass(5, 3, 0, 1, -1, -1);
      checkOutput("p1_col_enable_cycles", 32'(obsColEn),   32'd27);
      checkOutput("p1_row_done_count",    32'(obsRowDone), 32'd2);
      checkOutput("p1_done_count",        32'(obsDone),    32'd1);
      checkOutput("p1_cfg_load_count",    32'(obsLoad),    32'd1);

      // I=7 K=3 stride 2 under random traffic and config churn after latching.
      runPass(7, 3, 1, 0, -1, -1);
      checkOutput("p2_cfg_load_count", 32'(obsLoad),    32'd1);
      checkOutput("p2_done_count",     32'(obsDone),    32'd1);
      checkOutput("p2_row_done_count", 32'(obsRowDone), 32'd2);

      // Illegal configs: image smaller than kernel, then empty kernel.
      runPass(2, 3, 0, 0, -1, -1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("ill1_cfg_load_count", 32'(obsLoad), 32'd0);
      checkOutput("ill1_done_count",     32'(obsDone), 32'd0);
      runPass(5, 0, 0, 0, -1, -1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("ill2_cfg_load_count", 32'(obsLoad), 32'd0);
      checkOutput("ill2_done_count",     32'(obsDone), 32'd0);

      // Toggling in_ready, then reset in the middle of row 1 kernel row 1.
      runPass(6, 3, 0, 2, 1, 1);
      doReset();
      runPass(6, 3, 0, 2, -1, -1);
      checkOutput("p3_done_count",     32'(obsDone),    32'd1);
      checkOutput("p3_row_done_count", 32'(obsRowDone), 32'd3);

      // K=1 and single-row passes.
      runPass(4, 1, 0, 0, -1, -1);
      checkOutput("k1_row_done_count", 32'(obsRowDone), 32'd3);
      runPass(3, 3, 0, 0, -1, -1);
      checkOutput("o1_row_done_count", 32'(obsRowDone), 32'd0);
      runPass(4, 3, 1, 0, -1, -1);
      checkOutput("o1s2_row_done_count", 32'(obsRowDone), 32'd0);
      checkOutput("o1s2_done_count",     32'(obsDone),    32'd1);

      // Random configurations, legal and illegal.
      for (int n = 0; n < 8; n++) begin
         runPass($urandom_range(0, 12), $urandom_range(0, 5), $urandom_range(0, 1), 0, -1, -1);
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
